// File: rtl/cursor_editor.sv
// ============================================================================
// cursor_editor
// ----------------------------------------------------------------------------
// Edit-mode front end for the pipe map. It sits upstream of the world block.
//
// The block takes debounced button levels and detects rising edges (presses).
// Each accepted press starts a lockout window, during which new presses are
// ignored. The pause button switches between RUN and EDIT. While in EDIT, the
// direction buttons move a 1-based map cursor, and change_item cycles the item
// under the cursor and writes it to the map.
//
// Ports
//   clock_50              in   1  system clock (50 MHz)
//   reset_key             in   1  asynchronous reset, active-low
//   debounce_up           in   1  debounced button level, 1 = pressed
//   debounce_down         in   1  debounced button level, 1 = pressed
//   debounce_left         in   1  debounced button level, 1 = pressed
//   debounce_right        in   1  debounced button level, 1 = pressed
//   debounce_change_item  in   1  debounced button level, 1 = pressed
//   debounce_pause        in   1  debounced button level, 1 = pressed
//   robot_row             in   8  current robot row
//   robot_column          in   8  current robot column
//   pause_flag            out  1  1 = robot halted, edit mode active
//   cursor_row            out  8  cursor row, 1..ROWS
//   cursor_column         out  8  cursor column, 1..COLS
//   cursor_item           out  4  selected item code, 0..ITEM_COUNT-1
//   map_we                out  1  single-cycle map write strobe
//   map_wr_row            out  8  write row, valid while map_we=1
//   map_wr_column         out  8  write column, valid while map_we=1
//   map_wr_item           out  4  write data, valid while map_we=1
//   lockout_busy          out  1  1 while the lockout counter is nonzero
// ============================================================================
module cursor_editor #(
   parameter int ROWS           = 10,
   parameter int COLS           = 20,
   parameter int ITEM_COUNT     = 4,
   parameter int LOCKOUT_CYCLES = 1_000_000
) (
   input  logic       clock_50,
   input  logic       reset_key,
   input  logic       debounce_up,
   input  logic       debounce_down,
   input  logic       debounce_left,
   input  logic       debounce_right,
   input  logic       debounce_change_item,
   input  logic       debounce_pause,
   input  logic [7:0] robot_row,
   input  logic [7:0] robot_column,
   output logic       pause_flag,
   output logic [7:0] cursor_row,
   output logic [7:0] cursor_column,
   output logic [3:0] cursor_item,
   output logic       map_we,
   output logic [7:0] map_wr_row,
   output logic [7:0] map_wr_column,
   output logic [3:0] map_wr_item,
   output logic       lockout_busy
);

   // The counter only has to hold LOCKOUT_CYCLES-1.
   localparam int         CW        = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LP_LOAD = CW'(LOCKOUT_CYCLES - 1);
   localparam logic [7:0] LP_ROWS   = 8'(ROWS);
   localparam logic [7:0] LP_COLS   = 8'(COLS);
   localparam logic [3:0] LP_LAST   = 4'(ITEM_COUNT - 1);

   typedef enum logic {
      S_RUN  = 1'b0,
      S_EDIT = 1'b1
   } state_t;

   state_t          r_state;
   logic [5:0]      r_prev;
   logic [CW-1:0]   r_lock;
   logic [7:0]      r_row;
   logic [7:0]      r_col;
   logic [3:0]      r_item;
   logic            r_map_we;
   logic [7:0]      r_wr_row;
   logic [7:0]      r_wr_col;
   logic [3:0]      r_wr_item;

   logic [5:0]      w_level;
   logic [5:0]      w_press;
   logic            w_idle;
   logic            w_accept;
   logic            w_blocked;
   logic [3:0]      w_item_n;

   // Button bit order also encodes the priority: bit 5 is the highest.
   assign w_level = {debounce_pause, debounce_up, debounce_down,
                     debounce_left, debounce_right, debounce_change_item};

   // A press is a rising edge against last cycle's level. The previous-level
   // register is updated every cycle, so a held button yields one press only.
   assign w_press  = w_level & ~r_prev;
   assign w_idle   = (r_lock == '0);
   assign w_accept = w_idle && (|w_press);

   assign w_blocked = (r_row == robot_row) && (r_col == robot_column);
   assign w_item_n  = (r_item >= LP_LAST) ? 4'd0 : r_item + 4'd1;

   always_ff @(posedge clock_50 or negedge reset_key) begin
      if (!reset_key) begin
         r_state   <= S_RUN;
         r_prev    <= '0;
         r_lock    <= '0;
         r_row     <= 8'd1;
         r_col     <= 8'd1;
         r_item    <= 4'd0;
         r_map_we  <= 1'b0;
         r_wr_row  <= 8'd0;
         r_wr_col  <= 8'd0;
         r_wr_item <= 4'd0;
      end else begin
         r_prev   <= w_level;
         r_map_we <= 1'b0;

         // Every accepted press restarts lockout, even when it has no effect.
         if (w_accept) begin
            r_lock <= LP_LOAD;
         end else if (!w_idle) begin
            r_lock <= r_lock - CW'(1);
         end

         // The if/else chain gives the priority. Lower-priority presses
         // in the same cycle are dropped.
         if (w_accept) begin
            if (w_press[5]) begin
               r_state <= (r_state == S_RUN) ? S_EDIT : S_RUN;
            end else if (r_state == S_EDIT) begin
               if (w_press[4]) begin
                  if (r_row > 8'd1) r_row <= r_row - 8'd1;
               end else if (w_press[3]) begin
                  if (r_row < LP_ROWS) r_row <= r_row + 8'd1;
               end else if (w_press[2]) begin
                  if (r_col > 8'd1) r_col <= r_col - 8'd1;
               end else if (w_press[1]) begin
                  if (r_col < LP_COLS) r_col <= r_col + 8'd1;
               end else if (!w_blocked) begin
                  // change_item: do not overwrite the tile the robot stands on.
                  r_item    <= w_item_n;
                  r_map_we  <= 1'b1;
                  r_wr_row  <= r_row;
                  r_wr_col  <= r_col;
                  r_wr_item <= w_item_n;
               end
            end
         end
      end
   end

   assign pause_flag    = (r_state == S_EDIT);
   assign cursor_row    = r_row;
   assign cursor_column = r_col;
   assign cursor_item   = r_item;
   assign map_we        = r_map_we;
   assign map_wr_row    = r_wr_row;
   assign map_wr_column = r_wr_col;
   assign map_wr_item   = r_wr_item;
   assign lockout_busy  = !w_idle;

endmodule
